stream_demux: RTL and testbench
===============================

# stream_demux

Parametrised, registered 1-to-N_OUT packet demultiplexer with per-channel valid/ready handshake. It supersedes the combinational select-and-gate demux for streaming paths: the destination is latched on the first beat of a packet and held until the last beat, and every beat passes through one output register. Illegal destinations can be dropped and counted. It sits between a single upstream producer and N_OUT downstream consumers.

## Interface
- N_OUT, 8: number of output channels, 2..256
- WIDTH, 8: data width in bits
- SEL_W, 3: select width; must satisfy 2^SEL_W >= N_OUT
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- en  input  1  packet-start enable, sampled only in IDLE
- in_data  input  WIDTH  beat data
- in_sel  input  SEL_W  destination channel, sampled on the first beat only
- in_last  input  1  marks the final beat of a packet
- in_valid  input  1  upstream beat valid
- in_ready  output  1  upstream beat accepted when in_valid && in_ready
- out_data  output  WIDTH  registered data, shared by all channels
- out_last  output  1  registered last flag, shared
- out_valid  output  N_OUT  one-hot valid, or all zero
- out_ready  input  N_OUT  per-channel ready; only the bit of the active channel is observed
- cur_sel  output  SEL_W  channel of the open packet, or of the held beat
- busy  output  1  state != IDLE or output register occupied
- drop_cnt  output  16  count of dropped packets

## Operation
- Output register fields:
  - v: occupied flag
  - d: data
  - l: last flag
  - ch: destination channel
- Outputs from the register: out_valid = v ? (1 << ch) : 0; out_data = d; out_last = l.
- Drain: a drain occurs when v && out_ready[ch]. On a drain with no load in the same cycle, v clears. d and l retain their values.
- Free: free = !v || out_ready[ch].
- States:
  - IDLE: no packet open.
  - FWD: packet open to a legal channel.
  - DROP: packet open to an illegal channel.
- in_ready:
  - IDLE: en && free
  - FWD: free
  - DROP: 1
- Accepted beat in IDLE, in_sel < N_OUT:
  - Load the register (v=1, d, l, ch=in_sel) and latch cur_sel.
  - Next state is FWD if !in_last, otherwise stay IDLE.
- Accepted beat in IDLE, in_sel >= N_OUT:
  - Discard the beat, latch cur_sel, increment drop_cnt.
  - Next state is DROP if !in_last, otherwise stay IDLE.
- Accepted beat in FWD:
  - Load the register with ch = cur_sel; in_sel is ignored.
  - in_last returns the block to IDLE.
- Accepted beat in DROP:
  - Discard the beat.
  - in_last returns the block to IDLE.
- drop_cnt saturates at 0xFFFF.
- en is sampled only in IDLE. Deasserting en mid-packet does not stall the packet; the packet completes.
- A drain and a load in the same cycle: the register takes the new beat and v stays 1.

## Timing
- Reset values: state IDLE, v=0, out_valid=0, out_data=0, out_last=0, cur_sel=0, busy=0, drop_cnt=0, in_ready=0 during rst.
- Reset mid-packet: the open packet and any held beat are discarded. No out_valid is asserted in the cycle after rst deasserts.
- Latency: a beat accepted at edge k appears on out_valid/out_data after edge k. Minimum latency is 1 cycle.
- Throughput: one beat per cycle while out_ready[ch] stays high, including back-to-back packets to different channels. in_ready in IDLE depends combinationally on out_ready[ch] of the previous packet.
- out_data, out_last and out_valid hold stable while out_valid[ch] && !out_ready[ch].
- Single-beat packet (first beat has in_last=1): the block stays in IDLE and the beat is still forwarded.
- in_ready never depends on in_valid.

## Configuration
- STREAM_DEMUX_DROP_EN defined:
  - DROP state, discard behaviour and drop_cnt are built as described above.
- STREAM_DEMUX_DROP_EN undefined:
  - No DROP state; drop_cnt is tied to 0.
  - A first beat with in_sel >= N_OUT is clamped to channel N_OUT-1 and forwarded as a legal packet.

## Test plan
- Reset then idle: assert rst for 3 cycles with in_valid=1. Required: out_valid=0, in_ready=0, drop_cnt=0, busy=0 throughout.
- Streaming: N_OUT=8, WIDTH=8. 4-beat packet (0x11..0x14), in_sel=5, all out_ready=1. Required:
  - out_valid=8'b0010_0000 for 4 consecutive cycles, each 1 cycle after acceptance.
  - out_last=1 on 0x14.
  - in_sel toggled mid-packet has no effect.
- Backpressure: out_ready[5]=0 for 3 cycles mid-packet. Required:
  - in_ready=0 for those cycles.
  - out_data holds at the same value.
  - No beat is lost or duplicated.
  - A change on out_ready[2] has no effect.
- Back-to-back single-beat packets to channels 1, 6, 1 with in_valid held high. Required: out_valid=0x02, 0x40, 0x02 on consecutive cycles.
- Illegal destination: N_OUT=6, in_sel=7, 3-beat packet, STREAM_DEMUX_DROP_EN defined. Required: in_ready=1 for all 3 beats, no out_valid, drop_cnt=1. With the macro undefined: the beats appear on channel 5.
- en and reset: deassert en mid-packet and the packet completes; the next packet is then refused (in_ready=0) until en=1. Assert rst during beat 2 of 4: out_valid=0 next cycle and the state returns to IDLE.

Source files
------------

// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one upstream beat port, N_OUT downstream valid/ready
// channels sharing data/last, plus status.
interface stream_demux_if #(
  parameter int N_OUT = 8,
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             en;
  logic [WIDTH-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [N_OUT-1:0] out_valid;
  logic [N_OUT-1:0] out_ready;
  logic [SEL_W-1:0] cur_sel;
  logic             busy;
  logic [15:0]      drop_cnt;

  modport master (
    output en, in_data, in_sel, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid, cur_sel, busy, drop_cnt
  );

  modport slave (
    input  en, in_data, in_sel, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid, cur_sel, busy, drop_cnt
  );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-N_OUT packet demux; destination latched on the first beat of each packet.
// Define STREAM_DEMUX_DROP_EN to drop and count packets to illegal channels (else clamp to N_OUT-1).
module stream_demux #(
  parameter int N_OUT = 8,
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input logic           clk,
  input logic           rst,
  stream_demux_if.slave bus
);

`ifdef STREAM_DEMUX_DROP_EN
  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
`else
  typedef enum logic [1:0] {IDLE, FWD} state_t;
`endif

  state_t           state_q, state_d;
  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             l_q, l_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] cur_q, cur_d;
`ifdef STREAM_DEMUX_DROP_EN
  logic [15:0]      cnt_q, cnt_d;
`endif

  logic             ready_ch;
  logic             free;
  logic             legal;
  logic [SEL_W-1:0] first_ch;
  logic             rdy;
  logic             accept;
  logic [N_OUT-1:0] ov;

  // Only the ready bit of the held beat's channel is ever observed.
  always_comb begin
    ready_ch = 1'b0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (ch_q == SEL_W'(i)) ready_ch = bus.out_ready[i];
    end
  end

  assign free  = !v_q || ready_ch;
  assign legal = (32'(bus.in_sel) < N_OUT);

`ifdef STREAM_DEMUX_DROP_EN
  assign first_ch = bus.in_sel;
`else
  assign first_ch = legal ? bus.in_sel : SEL_W'(N_OUT - 1);
`endif

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    d_d     = d_q;
    l_d     = l_q;
    ch_d    = ch_q;
    cur_d   = cur_q;
`ifdef STREAM_DEMUX_DROP_EN
    cnt_d   = cnt_q;
`endif
    rdy     = 1'b0;

    if (v_q && ready_ch) v_d = 1'b0;

    unique case (state_q)
      IDLE:    rdy = bus.en && free;
      FWD:     rdy = free;
`ifdef STREAM_DEMUX_DROP_EN
      DROP:    rdy = 1'b1;
`endif
      default: rdy = 1'b0;
    endcase
    if (rst) rdy = 1'b0;

    accept = bus.in_valid && rdy;

    // A load overrides the drain-clear above, so a simultaneous drain+load keeps v set.
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          cur_d = first_ch;
`ifdef STREAM_DEMUX_DROP_EN
          if (legal) begin
`endif
            v_d  = 1'b1;
            d_d  = bus.in_data;
            l_d  = bus.in_last;
            ch_d = first_ch;
            if (!bus.in_last) state_d = FWD;
`ifdef STREAM_DEMUX_DROP_EN
          end else begin
            if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
            if (!bus.in_last) state_d = DROP;
          end
`endif
        end
        FWD: begin
          v_d  = 1'b1;
          d_d  = bus.in_data;
          l_d  = bus.in_last;
          ch_d = cur_q;
          if (bus.in_last) state_d = IDLE;
        end
`ifdef STREAM_DEMUX_DROP_EN
        DROP: begin
          if (bus.in_last) state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= 1'b0;
      d_q     <= '0;
      l_q     <= 1'b0;
      ch_q    <= '0;
      cur_q   <= '0;
`ifdef STREAM_DEMUX_DROP_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      d_q     <= d_d;
      l_q     <= l_d;
      ch_q    <= ch_d;
      cur_q   <= cur_d;
`ifdef STREAM_DEMUX_DROP_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    ov = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      ov[i] = v_q && (ch_q == SEL_W'(i));
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ov;
  assign bus.out_data  = d_q;
  assign bus.out_last  = l_q;
  assign bus.cur_sel   = cur_q;
  assign bus.busy      = (state_q != IDLE) || v_q;
`ifdef STREAM_DEMUX_DROP_EN
  assign bus.drop_cnt  = cnt_q;
`else
  assign bus.drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: an 8-channel instance for streaming/backpressure/en/reset
// and a 6-channel instance for the illegal-destination path (drop or clamp, by build macro).
module tb_stream_demux;

`ifdef STREAM_DEMUX_DROP_EN
  localparam bit DROP_BUILD = 1'b1;
`else
  localparam bit DROP_BUILD = 1'b0;
`endif

  typedef struct {
    logic [2:0] ch;
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    fails  = 0;
  beat_t q8[$];
  beat_t q6[$];
  beat_t e8, e6;

  always #5 clk = ~clk;

  stream_demux_if #(.N_OUT(8), .WIDTH(8), .SEL_W(3)) a8 ();
  stream_demux_if #(.N_OUT(6), .WIDTH(8), .SEL_W(3)) a6 ();

  stream_demux #(.N_OUT(8), .WIDTH(8), .SEL_W(3)) dut8 (.clk(clk), .rst(rst), .bus(a8));
  stream_demux #(.N_OUT(6), .WIDTH(8), .SEL_W(3)) dut6 (.clk(clk), .rst(rst), .bus(a6));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one beat on dut8 (w=0) or dut6 (w=1), wait for acceptance, optionally check the
  // registered output one cycle later against a hand-computed one-hot.
  task automatic beat(input bit w, input logic [7:0] d, input logic [2:0] s, input bit l,
                      input bit fwd, input logic [2:0] ch, input bit lat,
                      input logic [7:0] exp_ov, input bit must_rdy);
    int unsigned n;
    logic        r;
    n = 0;
    if (!w) begin
      a8.in_data = d; a8.in_sel = s; a8.in_last = l; a8.in_valid = 1'b1;
    end else begin
      a6.in_data = d; a6.in_sel = s; a6.in_last = l; a6.in_valid = 1'b1;
    end
    @(negedge clk);
    r = w ? a6.in_ready : a8.in_ready;
    while (!r && n < 50) begin
      @(negedge clk);
      n++;
      r = w ? a6.in_ready : a8.in_ready;
    end
    check("accept_wait", 32'(r), 32'd1);
    if (must_rdy) check("in_ready_immediate", n, 32'd0);
    if (fwd) begin
      if (!w) q8.push_back('{ch, d, l});
      else    q6.push_back('{ch, d, l});
    end
    @(posedge clk);
    #1;
    if (lat) begin
      if (!w) begin
        check("lat_valid8", 32'(a8.out_valid), 32'(exp_ov));
        check("lat_data8", 32'(a8.out_data), 32'(d));
        check("lat_last8", 32'(a8.out_last), 32'(l));
      end else begin
        check("lat_valid6", 32'(a6.out_valid), 32'(exp_ov));
        if (fwd) check("lat_data6", 32'(a6.out_data), 32'(d));
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    a8.in_valid = 1'b0;
    a6.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every drain on either instance must match the next expected beat.
  always @(negedge clk) begin
    if (!rst && (a8.out_valid & a8.out_ready) != '0) begin
      if (q8.size() == 0) check("dut8_unexpected_beat", 32'(a8.out_valid), 32'd0);
      else begin
        e8 = q8.pop_front();
        check("sb8_valid", 32'(a8.out_valid), 32'd1 << e8.ch);
        check("sb8_data", 32'(a8.out_data), 32'(e8.d));
        check("sb8_last", 32'(a8.out_last), 32'(e8.l));
      end
    end
    if (!rst && (a6.out_valid & a6.out_ready) != '0) begin
      if (q6.size() == 0) check("dut6_unexpected_beat", 32'(a6.out_valid), 32'd0);
      else begin
        e6 = q6.pop_front();
        check("sb6_valid", 32'(a6.out_valid), 32'd1 << e6.ch);
        check("sb6_data", 32'(a6.out_data), 32'(e6.d));
        check("sb6_last", 32'(a6.out_last), 32'(e6.l));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a8.en = 1'b1; a8.in_data = 8'h00; a8.in_sel = 3'd0; a8.in_last = 1'b0; a8.in_valid = 1'b1;
    a8.out_ready = '1;
    a6.en = 1'b1; a6.in_data = 8'h00; a6.in_sel = 3'd0; a6.in_last = 1'b0; a6.in_valid = 1'b1;
    a6.out_ready = '1;

    // Reset held 3 cycles with in_valid high
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid8", 32'(a8.out_valid), 32'd0);
      check("rst_in_ready8", 32'(a8.in_ready), 32'd0);
      check("rst_drop_cnt8", 32'(a8.drop_cnt), 32'd0);
      check("rst_busy8", 32'(a8.busy), 32'd0);
      check("rst_in_ready6", 32'(a6.in_ready), 32'd0);
      check("rst_out_valid6", 32'(a6.out_valid), 32'd0);
    end
    check("rst_out_data8", 32'(a8.out_data), 32'd0);
    check("rst_cur_sel8", 32'(a8.cur_sel), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Streaming 4 beats to channel 5, in_sel toggled mid-packet
    beat(0, 8'h11, 3'd5, 1'b0, 1, 3'd5, 1, 8'h20, 1);
    beat(0, 8'h12, 3'd2, 1'b0, 1, 3'd5, 1, 8'h20, 1);
    beat(0, 8'h13, 3'd0, 1'b0, 1, 3'd5, 1, 8'h20, 1);
    beat(0, 8'h14, 3'd7, 1'b1, 1, 3'd5, 1, 8'h20, 1);
    check("stream_cur_sel", 32'(a8.cur_sel), 32'd5);
    idle(2);
    check("stream_busy_after", 32'(a8.busy), 32'd0);

    // Backpressure on channel 5 for 3 cycles; out_ready[2] wiggles meanwhile
    beat(0, 8'h21, 3'd5, 1'b0, 1, 3'd5, 1, 8'h20, 1);
    beat(0, 8'h22, 3'd5, 1'b0, 1, 3'd5, 1, 8'h20, 1);
    a8.out_ready[5] = 1'b0;
    a8.out_ready[2] = 1'b0;
    a8.in_data = 8'h23; a8.in_sel = 3'd5; a8.in_last = 1'b0; a8.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(a8.in_ready), 32'd0);
      check("bp_hold_data", 32'(a8.out_data), 32'h22);
      check("bp_hold_valid", 32'(a8.out_valid), 32'h20);
      @(posedge clk);
      #1;
      a8.out_ready[2] = ~a8.out_ready[2];
    end
    a8.out_ready = '1;
    beat(0, 8'h23, 3'd5, 1'b0, 1, 3'd5, 1, 8'h20, 0);
    beat(0, 8'h24, 3'd5, 1'b1, 1, 3'd5, 1, 8'h20, 1);
    idle(2);

    // Back-to-back single-beat packets to channels 1, 6, 1
    beat(0, 8'hA1, 3'd1, 1'b1, 1, 3'd1, 1, 8'h02, 1);
    beat(0, 8'hA2, 3'd6, 1'b1, 1, 3'd6, 1, 8'h40, 1);
    beat(0, 8'hA3, 3'd1, 1'b1, 1, 3'd1, 1, 8'h02, 1);
    idle(2);

    // en dropped mid-packet: packet completes, next packet waits for en
    beat(0, 8'h61, 3'd3, 1'b0, 1, 3'd3, 1, 8'h08, 1);
    a8.en = 1'b0;
    beat(0, 8'h62, 3'd3, 1'b0, 1, 3'd3, 1, 8'h08, 1);
    beat(0, 8'h63, 3'd3, 1'b0, 1, 3'd3, 1, 8'h08, 1);
    beat(0, 8'h64, 3'd3, 1'b1, 1, 3'd3, 1, 8'h08, 1);
    a8.in_data = 8'h70; a8.in_sel = 3'd0; a8.in_last = 1'b1; a8.in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("en_low_in_ready", 32'(a8.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    a8.en = 1'b1;
    beat(0, 8'h70, 3'd0, 1'b1, 1, 3'd0, 1, 8'h01, 0);
    idle(2);

    // Reset during beat 2 of 4 with beat 1 still held
    a8.out_ready[4] = 1'b0;
    beat(0, 8'h41, 3'd4, 1'b0, 1, 3'd4, 1, 8'h10, 1);
    rst = 1'b1;
    a8.in_data = 8'h42; a8.in_sel = 3'd4; a8.in_last = 1'b0; a8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a8.in_valid = 1'b0;
    q8.delete();
    check("midrst_out_valid", 32'(a8.out_valid), 32'd0);
    check("midrst_busy", 32'(a8.busy), 32'd0);
    check("midrst_cur_sel", 32'(a8.cur_sel), 32'd0);
    @(negedge clk);
    check("midrst_out_valid_next", 32'(a8.out_valid), 32'd0);
    @(posedge clk);
    #1;
    a8.out_ready = '1;
    beat(0, 8'h51, 3'd0, 1'b1, 1, 3'd0, 1, 8'h01, 1);
    idle(2);

    // Illegal destination on the 6-channel instance
    beat(1, 8'h31, 3'd7, 1'b0, !DROP_BUILD, 3'd5, 1, DROP_BUILD ? 8'h00 : 8'h20, 1);
    beat(1, 8'h32, 3'd7, 1'b0, !DROP_BUILD, 3'd5, 1, DROP_BUILD ? 8'h00 : 8'h20, 1);
    beat(1, 8'h33, 3'd7, 1'b1, !DROP_BUILD, 3'd5, 1, DROP_BUILD ? 8'h00 : 8'h20, 1);
    check("illegal_drop_cnt", 32'(a6.drop_cnt), DROP_BUILD ? 32'd1 : 32'd0);
    check("illegal_cur_sel", 32'(a6.cur_sel), DROP_BUILD ? 32'd7 : 32'd5);
    idle(2);
    check("illegal_busy_after", 32'(a6.busy), 32'd0);
    check("dut8_drop_cnt", 32'(a8.drop_cnt), 32'd0);

    check("q8_drained", q8.size(), 32'd0);
    check("q6_drained", q6.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
